// File: rtl/forward_control_unit.sv
// Operand-forwarding and load-use hazard control for a five-stage pipeline.
// It tracks destination tags for the ALU, MEM and WB stages and produces registered ALU mux selects.
module forward_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        decValid,
    input  logic [4:0]  decRs1Addr,
    input  logic [4:0]  decRs2Addr,
    input  logic        decRs1Used,
    input  logic        decRs2Used,
    input  logic [4:0]  decRdAddr,
    input  logic        decRegWrite,
    input  logic        decMemRead,
    input  logic        flush,
    output logic [1:0]  select1,
    output logic [1:0]  select2,
    output logic        stall,
    output logic [15:0] stallCount
);

    localparam logic [1:0] SEL_REG     = 2'b00;
    localparam logic [1:0] SEL_ALU_MEM = 2'b01;
    localparam logic [1:0] SEL_MEM_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd_addr;
        logic       reg_write;
        logic       mem_read;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    tag_t        alu_tag_q, alu_tag_d;
    tag_t        mem_tag_q, mem_tag_d;
    tag_t        wb_tag_q, wb_tag_d;
    logic [1:0]  select1_q, select1_d;
    logic [1:0]  select2_q, select2_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        hazard;
    logic        issue;

    function automatic logic produces(input tag_t t, input logic [4:0] r);
        return t.valid && t.reg_write && (t.rd_addr == r) && (r != 5'd0);
    endfunction

    // The youngest producer wins, so the ALU tag is checked before the MEM tag.
    function automatic logic [1:0] fwd_select(input logic used, input logic [4:0] r,
                                              input tag_t alu, input tag_t mem);
        logic [1:0] sel;
        sel = SEL_REG;
        if (used) begin
            if (produces(alu, r)) begin
                sel = SEL_ALU_MEM;
            end else if (produces(mem, r)) begin
                sel = SEL_MEM_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (decValid && !flush && alu_tag_q.mem_read) begin
            hazard = (decRs1Used && produces(alu_tag_q, decRs1Addr)) ||
                     (decRs2Used && produces(alu_tag_q, decRs2Addr));
        end
        issue = decValid && !flush && !hazard;

        alu_tag_d = TAG_BUBBLE;
        select1_d = SEL_REG;
        select2_d = SEL_REG;
        if (issue) begin
            alu_tag_d.valid     = 1'b1;
            alu_tag_d.rd_addr   = decRdAddr;
            alu_tag_d.reg_write = decRegWrite;
            alu_tag_d.mem_read  = decMemRead;
            select1_d = fwd_select(decRs1Used, decRs1Addr, alu_tag_q, mem_tag_q);
            select2_d = fwd_select(decRs2Used, decRs2Addr, alu_tag_q, mem_tag_q);
        end

        // Downstream stages never stall; a stall only bubbles the ALU stage.
        mem_tag_d = alu_tag_q;
        wb_tag_d  = mem_tag_q;

        stall_count_d = stall_count_q;
        if (hazard && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_tag_q     <= TAG_BUBBLE;
            mem_tag_q     <= TAG_BUBBLE;
            wb_tag_q      <= TAG_BUBBLE;
            select1_q     <= SEL_REG;
            select2_q     <= SEL_REG;
            stall_count_q <= 16'd0;
        end else begin
            alu_tag_q     <= alu_tag_d;
            mem_tag_q     <= mem_tag_d;
            wb_tag_q      <= wb_tag_d;
            select1_q     <= select1_d;
            select2_q     <= select2_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign select1    = select1_q;
    assign select2    = select2_q;
    assign stall      = hazard;
    assign stallCount = stall_count_q;

endmodule

// File: tb/tb_forward_control_unit.sv
// Directed self-checking bench for forward_control_unit: forwarding distances,
// load-use stall, x0, flush and asynchronous reset behaviour.
module tb_forward_control_unit;

    logic        clk;
    logic        rst;
    logic        decValid;
    logic [4:0]  decRs1Addr;
    logic [4:0]  decRs2Addr;
    logic        decRs1Used;
    logic        decRs2Used;
    logic [4:0]  decRdAddr;
    logic        decRegWrite;
    logic        decMemRead;
    logic        flush;
    logic [1:0]  select1;
    logic [1:0]  select2;
    logic        stall;
    logic [15:0] stallCount;

    int checks = 0;
    int errors = 0;

    forward_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .decValid   (decValid),
        .decRs1Addr (decRs1Addr),
        .decRs2Addr (decRs2Addr),
        .decRs1Used (decRs1Used),
        .decRs2Used (decRs2Used),
        .decRdAddr  (decRdAddr),
        .decRegWrite(decRegWrite),
        .decMemRead (decMemRead),
        .flush      (flush),
        .select1    (select1),
        .select2    (select2),
        .stall      (stall),
        .stallCount (stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic fl);
        decValid    = v;
        decRs1Addr  = rs1;
        decRs1Used  = u1;
        decRs2Addr  = rs2;
        decRs2Used  = u2;
        decRdAddr   = rd;
        decRegWrite = rw;
        decMemRead  = mr;
        flush       = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubbles(input int n);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("reset_sel1", {14'd0, select1}, 16'd0);
        checkOutput("reset_sel2", {14'd0, select2}, 16'd0);
        checkOutput("reset_stall", {15'd0, stall}, 16'd0);
        checkOutput("reset_count", stallCount, 16'd0);
        rst = 1'b1;
        tick();

        // back-to-back ALU dependency: add x5 ; sub rs1=x5
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("b2b_add_stall", {15'd0, stall}, 16'd0);
        tick();
        checkOutput("b2b_add_sel1", {14'd0, select1}, 16'd0);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("b2b_sub_stall", {15'd0, stall}, 16'd0);
        tick();
        checkOutput("b2b_sub_sel1", {14'd0, select1}, 16'd1);
        checkOutput("b2b_sub_sel2", {14'd0, select2}, 16'd0);
        bubbles(1);
        checkOutput("bubble_sel1", {14'd0, select1}, 16'd0);
        bubbles(2);

        // distance two: addi x7 ; independent ; use rs2=x7
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd13, 1'b1, 5'd7, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("dist2_sel1", {14'd0, select1}, 16'd0);
        checkOutput("dist2_sel2", {14'd0, select2}, 16'd2);
        bubbles(3);

        // load-use: lw x3 ; add rs1=x3
        applyStimulus(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("lu_stall_on", {15'd0, stall}, 16'd1);
        checkOutput("lu_count_before", stallCount, 16'd0);
        tick();
        checkOutput("lu_count_after", stallCount, 16'd1);
        checkOutput("lu_bubble_sel1", {14'd0, select1}, 16'd0);
        checkOutput("lu_stall_off", {15'd0, stall}, 16'd0);
        tick();
        checkOutput("lu_sel1", {14'd0, select1}, 16'd2);
        checkOutput("lu_sel2", {14'd0, select2}, 16'd0);
        checkOutput("lu_count_hold", stallCount, 16'd1);
        bubbles(3);

        // double producer: addi x4 ; ori x4 ; consumer of x4
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("dbl_ori_sel1", {14'd0, select1}, 16'd1);
        applyStimulus(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("dbl_sel1", {14'd0, select1}, 16'd1);
        checkOutput("dbl_sel2", {14'd0, select2}, 16'd1);
        bubbles(3);

        // x0 never forwarded; unused source selects Reg
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("x0_sel1", {14'd0, select1}, 16'd0);
        checkOutput("x0_sel2", {14'd0, select2}, 16'd0);
        applyStimulus(1'b1, 5'd11, 1'b0, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("unused_sel1", {14'd0, select1}, 16'd0);
        checkOutput("used_sel2", {14'd0, select2}, 16'd1);
        bubbles(3);

        // flush beats a load-use hazard
        applyStimulus(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
        #1 checkOutput("flush_stall", {15'd0, stall}, 16'd0);
        tick();
        checkOutput("flush_sel1", {14'd0, select1}, 16'd0);
        checkOutput("flush_sel2", {14'd0, select2}, 16'd0);
        checkOutput("flush_count", stallCount, 16'd1);
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("postflush_stall", {15'd0, stall}, 16'd0);
        tick();
        checkOutput("postflush_sel1", {14'd0, select1}, 16'd2);
        bubbles(3);

        // reset pulse with a pending load-use hazard
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("rstp_lw_sel1", {14'd0, select1}, 16'd1);
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("rstp_stall_pre", {15'd0, stall}, 16'd1);
        checkOutput("rstp_count_pre", stallCount, 16'd1);
        rst = 1'b0;
        #1;
        checkOutput("rstp_stall", {15'd0, stall}, 16'd0);
        checkOutput("rstp_sel1", {14'd0, select1}, 16'd0);
        checkOutput("rstp_count", stallCount, 16'd0);
        #1 rst = 1'b1;
        #1 checkOutput("rstrel_stall", {15'd0, stall}, 16'd0);
        tick();
        checkOutput("rstrel_sel1", {14'd0, select1}, 16'd0);
        checkOutput("rstrel_count", stallCount, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_control_unit.md
FORWARD_CONTROL_UNIT -- requirements
Module: forwardControlUnit

Interface
REQ-001 The block SHALL use a single clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 decValid  in  1  DEC stage holds a real instruction.
REQ-005 decRs1Addr, decRs2Addr  in  5 each  source register addresses of the DEC-stage instruction.
REQ-006 decRs1Used, decRs2Used  in  1 each  the DEC-stage instruction reads that source.
REQ-007 decRdAddr  in  5  destination address of the DEC-stage instruction.
REQ-008 decRegWrite  in  1  the DEC-stage instruction writes decRdAddr.
REQ-009 decMemRead  in  1  the DEC-stage instruction is a load.
REQ-010 flush  in  1  the DEC-stage instruction is killed this cycle.
REQ-011 select1, select2  out  `ALUMuxSelectBus (2)  ALU operand mux selects for the instruction now in the ALU stage: `ALUMuxDataFromReg=2'b00, `ALUMuxDataFromALU_MEM=2'b01, `ALUMuxDataFromMEM_WB=2'b10.
REQ-012 stall  out  1  hold PC and IF_DEC; DEC_ALU loads a bubble.
REQ-013 stallCount  out  16  saturating count of load-use stall cycles.

Function
REQ-014 The block SHALL keep three internal tag stages (ALU, MEM, WB), each holding {valid, rdAddr, regWrite, memRead}.
REQ-015 Every cycle the MEM tag SHALL load the ALU tag and the WB tag SHALL load the MEM tag; downstream stages never stall.
REQ-016 The ALU tag SHALL load the DEC fields when decValid=1, stall=0 and flush=0; otherwise it SHALL load an invalid bubble.
REQ-017 A tag "produces r" only when valid=1, regWrite=1, rdAddr=r and r!=0.
REQ-018 stall SHALL be combinational: 1 when decValid=1, flush=0, the ALU tag has memRead=1 and produces an rsN that the DEC instruction uses (rsNUsed=1); otherwise 0.
REQ-019 Next select for operand N (registered, one-cycle latency) SHALL be computed from the DEC instruction and the current ALU and MEM tags:
- ALU_MEM (01) if the current ALU tag produces decRsNAddr;
- else MEM_WB (10) if the current MEM tag produces decRsNAddr;
- else Reg (00).
REQ-020 The youngest producer SHALL win: an ALU-tag match overrides a MEM-tag match.
REQ-021 Register x0 SHALL never be forwarded; an unused source (rsNUsed=0) SHALL select Reg.
REQ-022 When stall=1, flush=1 or decValid=0, select1 and select2 SHALL load Reg (00) on the next edge.
REQ-023 A load-use stall SHALL last exactly one cycle; on the following cycle the load sits in the MEM tag and the consumer's select resolves to MEM_WB.
REQ-024 Simultaneous flush and hazard: flush wins, so stall=0 and a bubble is inserted.
REQ-025 stallCount SHALL increment on each edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-026 The select codes 2'b11 SHALL never be driven.

Reset
REQ-027 While rst=0: all tags invalid, select1=select2=00, stallCount=0; stall therefore reads 0.
REQ-028 Reset asserted mid-operation SHALL discard all tags immediately, with no forwarding or stall on the first cycle after release.
REQ-029 Reset deassertion SHALL take effect synchronously at the next clk edge.

Verification
REQ-030 Back-to-back ALU dependency: add x5 followed by sub using rs1=x5 -> select1=01 and select2=00 in the sub's ALU cycle, and stall never asserts.
REQ-031 Distance-two dependency: addi x7, then an independent instruction, then an instruction using rs2=x7 -> select2=10 in its ALU cycle.
REQ-032 Load-use: lw x3 followed immediately by add using rs1=x3 -> stall=1 for exactly one cycle, stallCount 0->1, then select1=10.
REQ-033 Double producer: addi x4 and ori x4 back-to-back, then a consumer of x4 -> select=01, the younger ori wins.
REQ-034 x0 and flush: writer of x0 followed by a reader of x0 -> select=00. A lw x3 / add x3 hazard with flush=1 -> stall=0 and the bubble's selects are 00.
REQ-035 Reset pulse (rst=0) while a load-use hazard is pending -> stall and selects drop to 0 asynchronously and stallCount=0.
